// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register plus result select and register-file write port; optional retire counter under WB_RETIRE_COUNT_EN.
// Latency 1 cycle from capture to rf_* outputs; stall holds the slot (and its write), flush inserts a bubble.
module wb_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic            stall,
   input  logic            flush,
   input  logic            reg_write_in,
   input  logic            mem_to_reg_in,
   input  logic            lui_control_in,
   input  logic            jump_in,
   input  logic            jalr_in,
   input  logic [XLEN-1:0] alu_result_in,
   input  logic [XLEN-1:0] mem_data_in,
   input  logic [XLEN-1:0] pc_plus_4_in,
   input  logic [XLEN-1:0] lui_imm_in,
   input  logic [4:0]      rd_in,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_valid,
   output logic [31:0]     retire_count
);

   logic            valid_q;
   logic            reg_write_q;
   logic            mem_to_reg_q;
   logic            lui_control_q;
   logic            jump_q;
   logic            jalr_q;
   logic [XLEN-1:0] alu_result_q;
   logic [XLEN-1:0] mem_data_q;
   logic [XLEN-1:0] pc_plus_4_q;
   logic [XLEN-1:0] lui_imm_q;
   logic [4:0]      rd_q;

   // Flush only kills valid/write; the data fields are left as they were.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q       <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_to_reg_q  <= 1'b0;
         lui_control_q <= 1'b0;
         jump_q        <= 1'b0;
         jalr_q        <= 1'b0;
         alu_result_q  <= '0;
         mem_data_q    <= '0;
         pc_plus_4_q   <= '0;
         lui_imm_q     <= '0;
         rd_q          <= '0;
      end else if (flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
      end else if (!stall) begin
         valid_q       <= valid_in;
         reg_write_q   <= reg_write_in & valid_in;
         mem_to_reg_q  <= mem_to_reg_in;
         lui_control_q <= lui_control_in;
         jump_q        <= jump_in;
         jalr_q        <= jalr_in;
         alu_result_q  <= alu_result_in;
         mem_data_q    <= mem_data_in;
         pc_plus_4_q   <= pc_plus_4_in;
         lui_imm_q     <= lui_imm_in;
         rd_q          <= rd_in;
      end
   end

   // Link address wins over LUI, which wins over load data.
   always_comb begin
      rf_wdata = alu_result_q;
      if (jump_q || jalr_q)
         rf_wdata = pc_plus_4_q;
      else if (lui_control_q)
         rf_wdata = lui_imm_q;
      else if (mem_to_reg_q)
         rf_wdata = mem_data_q;
   end

   assign rf_we    = valid_q & reg_write_q & (rd_q != 5'd0);
   assign rf_waddr = rd_q;
   assign wb_valid = valid_q;

`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retire_cnt_q;

   // Counted at capture, so a stalled instruction is not counted twice.
   always_ff @(posedge clk) begin
      if (rst)
         retire_cnt_q <= '0;
      else if (valid_in && !stall && !flush)
         retire_cnt_q <= retire_cnt_q + 32'd1;
   end

   assign retire_count = retire_cnt_q;
`else
   assign retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with an instruction-level reference model checked every cycle.
module tb_wb_stage;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_in, stall, flush;
   logic            reg_write_in, mem_to_reg_in, lui_control_in, jump_in, jalr_in;
   logic [XLEN-1:0] alu_result_in, mem_data_in, pc_plus_4_in, lui_imm_in;
   logic [4:0]      rd_in;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            wb_valid;
   logic [31:0]     retire_count;

   int n_total = 0;
   int n_pass  = 0;

   // Model: the instruction sitting in WB, kept as its architectural result.
   bit          m_valid;
   bit          m_write;
   bit          m_known;
   logic [4:0]  m_rd;
   logic [31:0] m_data;
   logic [31:0] m_cnt;

   wb_stage #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .lui_control_in(lui_control_in), .jump_in(jump_in), .jalr_in(jalr_in),
      .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
      .pc_plus_4_in(pc_plus_4_in), .lui_imm_in(lui_imm_in), .rd_in(rd_in),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_valid(wb_valid), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [31:0] arch_result();
      if (jump_in || jalr_in) return pc_plus_4_in;
      if (lui_control_in)     return lui_imm_in;
      if (mem_to_reg_in)      return mem_data_in;
      return alu_result_in;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_valid = 0; m_write = 0; m_known = 1; m_rd = '0; m_data = '0; m_cnt = '0;
      end else if (flush) begin
         m_valid = 0; m_write = 0; m_known = 0;
      end else if (!stall) begin
         m_valid = valid_in;
         m_write = valid_in && reg_write_in && (rd_in != 5'd0);
         m_known = 1;
         m_rd    = rd_in;
         m_data  = arch_result();
`ifdef WB_RETIRE_COUNT_EN
         if (valid_in) m_cnt = m_cnt + 32'd1;
`endif
      end
   endtask

   // One clock: model follows the edge, then all outputs are compared mid-cycle.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      chk("rf_we", {31'd0, rf_we}, {31'd0, m_write});
      if (m_known) begin
         chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_rd});
         chk("rf_wdata", rf_wdata, m_data);
      end
      chk("retire_count", retire_count, m_cnt);
   endtask

   task automatic set_op(input bit v, input bit rw, input bit m2r, input bit lui,
                         input bit j, input bit jr, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc4,
                         input logic [31:0] imm, input logic [4:0] rd);
      valid_in = v; reg_write_in = rw; mem_to_reg_in = m2r; lui_control_in = lui;
      jump_in = j; jalr_in = jr; alu_result_in = alu; mem_data_in = mem;
      pc_plus_4_in = pc4; lui_imm_in = imm; rd_in = rd;
   endtask

   initial begin
      m_valid = 0; m_write = 0; m_known = 0; m_rd = '0; m_data = '0; m_cnt = '0;
      rst = 1; stall = 0; flush = 0;
      set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
      chk("reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("reset_rf_wdata", rf_wdata, 32'd0);
      chk("reset_retire", retire_count, 32'd0);
      rst = 0;

      set_op(1, 1, 0, 0, 0, 0, 32'h1234, 32'hDEAD, 32'h40, 32'h5000, 5'd5);
      tick();
      chk("alu_we", {31'd0, rf_we}, 32'd1);
      chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
      chk("alu_wdata", rf_wdata, 32'h1234);

      set_op(1, 1, 1, 0, 0, 0, 32'h1111, 32'hFFFF_FF80, 32'h44, 32'h6000, 5'd7);
      tick();
      chk("load_wdata", rf_wdata, 32'hFFFF_FF80);
      chk("load_waddr", {27'd0, rf_waddr}, 32'd7);

      set_op(1, 1, 1, 1, 1, 0, 32'h2222, 32'h3333, 32'h104, 32'hABCD_0000, 5'd1);
      tick();
      chk("jal_prio_wdata", rf_wdata, 32'h104);

      set_op(1, 1, 1, 1, 0, 0, 32'h2222, 32'h3333, 32'h108, 32'h1234_5000, 5'd2);
      tick();
      chk("lui_prio_wdata", rf_wdata, 32'h1234_5000);

      set_op(1, 1, 0, 0, 0, 1, 32'h2222, 32'h3333, 32'h200, 32'h7000, 5'd31);
      tick();
      chk("jalr_wdata", rf_wdata, 32'h200);

      set_op(1, 1, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      chk("x0_we", {31'd0, rf_we}, 32'd0);
      chk("x0_valid", {31'd0, wb_valid}, 32'd1);

      set_op(0, 1, 0, 0, 0, 0, 32'h66, 32'h0, 32'h0, 32'h0, 5'd3);
      tick();
      chk("bubble_we", {31'd0, rf_we}, 32'd0);
      chk("bubble_valid", {31'd0, wb_valid}, 32'd0);

      set_op(1, 1, 0, 0, 0, 0, 32'h99, 32'h0, 32'h0, 32'h0, 5'd9);
      tick();
      stall = 1;
      set_op(1, 1, 1, 0, 0, 0, 32'hFFFF, 32'hEEEE, 32'h0, 32'h0, 5'd4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_we", {31'd0, rf_we}, 32'd1);
         chk("stall_waddr", {27'd0, rf_waddr}, 32'd9);
         chk("stall_wdata", rf_wdata, 32'h99);
      end
      flush = 1;
      tick();
      chk("flush_valid", {31'd0, wb_valid}, 32'd0);
      chk("flush_we", {31'd0, rf_we}, 32'd0);
      stall = 0; flush = 0;

      set_op(1, 1, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 32'h0, 5'd9);
      tick();
      stall = 1;
      tick();
      rst = 1;
      tick();
      chk("rst_stall_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_stall_we", {31'd0, rf_we}, 32'd0);
      chk("rst_stall_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("rst_stall_wdata", rf_wdata, 32'd0);
      chk("rst_stall_retire", retire_count, 32'd0);
      rst = 0; stall = 0;

`ifdef WB_RETIRE_COUNT_EN
      dut.retire_cnt_q = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
`endif
      set_op(1, 1, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0, 32'h0, 5'd10);
      tick();
`ifdef WB_RETIRE_COUNT_EN
      chk("retire_1", retire_count, 32'hFFFF_FFFF);
`else
      chk("retire_off_1", retire_count, 32'd0);
`endif
      set_op(1, 1, 0, 0, 0, 0, 32'h2, 32'h0, 32'h0, 32'h0, 5'd11);
      tick();
`ifdef WB_RETIRE_COUNT_EN
      chk("retire_wrap", retire_count, 32'd0);
`else
      chk("retire_off_2", retire_count, 32'd0);
`endif
      set_op(1, 1, 0, 0, 0, 0, 32'h3, 32'h0, 32'h0, 32'h0, 5'd12);
      tick();
`ifdef WB_RETIRE_COUNT_EN
      chk("retire_3", retire_count, 32'd1);
`else
      chk("retire_off_3", retire_count, 32'd0);
`endif
      chk("last_wdata", rf_wdata, 32'h3);

      set_op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
